// File: rtl/pdp8_seq_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_seq_pkg
// Shared definitions for the PDP-8 major-cycle sequencer:
//   seq_state_t     - sequencer state encoding
//   EXEC_STEPS_MAX  - largest number of execute ck/stb pairs
//   PH_*            - bit positions of each phase output in the phase vector,
//                     shared with the fetch decoder's bench
//   phase_decode    - state -> one-hot phase vector
//   norm_steps      - execute-step count with 0 mapped to 1
// -----------------------------------------------------------------------------
package pdp8_seq_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH_CK  = 4'd1,
    FETCH_STB = 4'd2,
    DISPATCH  = 4'd3,
    AUTO1_CK  = 4'd4,
    AUTO1_STB = 4'd5,
    AUTO2_CK  = 4'd6,
    AUTO2_STB = 4'd7,
    IND_CK    = 4'd8,
    IND_STB   = 4'd9,
    EX1_CK    = 4'd10,
    EX1_STB   = 4'd11,
    EX2_CK    = 4'd12,
    EX2_STB   = 4'd13,
    EX3_CK    = 4'd14,
    EX3_STB   = 4'd15
  } seq_state_t;

  localparam int EXEC_STEPS_MAX = 3;

  localparam int NUM_PHASES   = 14;
  localparam int PH_CK_FETCH  = 0;
  localparam int PH_STB_FETCH = 1;
  localparam int PH_CK_AUTO1  = 2;
  localparam int PH_STB_AUTO1 = 3;
  localparam int PH_CK_AUTO2  = 4;
  localparam int PH_STB_AUTO2 = 5;
  localparam int PH_CK_IND    = 6;
  localparam int PH_STB_IND   = 7;
  localparam int PH_CK1       = 8;
  localparam int PH_STB1      = 9;
  localparam int PH_CK2       = 10;
  localparam int PH_STB2      = 11;
  localparam int PH_CK3       = 12;
  localparam int PH_STB3      = 13;

  // IDLE and DISPATCH map to an all-zero vector: no phase runs there.
  function automatic logic [NUM_PHASES-1:0] phase_decode(input seq_state_t s);
    logic [NUM_PHASES-1:0] v;
    v = {NUM_PHASES{1'b0}};
    case (s)
      FETCH_CK:  v[PH_CK_FETCH]  = 1'b1;
      FETCH_STB: v[PH_STB_FETCH] = 1'b1;
      AUTO1_CK:  v[PH_CK_AUTO1]  = 1'b1;
      AUTO1_STB: v[PH_STB_AUTO1] = 1'b1;
      AUTO2_CK:  v[PH_CK_AUTO2]  = 1'b1;
      AUTO2_STB: v[PH_STB_AUTO2] = 1'b1;
      IND_CK:    v[PH_CK_IND]    = 1'b1;
      IND_STB:   v[PH_STB_IND]   = 1'b1;
      EX1_CK:    v[PH_CK1]       = 1'b1;
      EX1_STB:   v[PH_STB1]      = 1'b1;
      EX2_CK:    v[PH_CK2]       = 1'b1;
      EX2_STB:   v[PH_STB2]      = 1'b1;
      EX3_CK:    v[PH_CK3]       = 1'b1;
      EX3_STB:   v[PH_STB3]      = 1'b1;
      default:   v = {NUM_PHASES{1'b0}};
    endcase
    return v;
  endfunction

  function automatic logic [1:0] norm_steps(input logic [1:0] n);
    if (n == 2'd0) begin
      return 2'd1;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// cycle_sequencer_if
// Control and phase-output bundle of the major-cycle sequencer.
//   run, step                - run/halt/single-step control
//   instIsIND, instIsPPIND   - decode flags, valid from DISPATCH
//   execSteps[1:0]           - execute pair count, valid in DISPATCH
//   ck*/stb* phase outputs   - one-clk phase strobes
//   instDone, halted         - instruction-end pulse and idle indicator
// master: the controller/decoder side; slave: the sequencer.
// -----------------------------------------------------------------------------
interface cycle_sequencer_if;
  logic       run;
  logic       step;
  logic       instIsIND;
  logic       instIsPPIND;
  logic [1:0] execSteps;

  logic ckFetch, stbFetch;
  logic ckAuto1, stbAuto1, ckAuto2, stbAuto2;
  logic ckInd, stbInd;
  logic ck1, stb1, ck2, stb2, ck3, stb3;
  logic instDone;
  logic halted;

  modport master (
    output run, step, instIsIND, instIsPPIND, execSteps,
    input  ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2,
    input  ckInd, stbInd, ck1, stb1, ck2, stb2, ck3, stb3,
    input  instDone, halted
  );

  modport slave (
    input  run, step, instIsIND, instIsPPIND, execSteps,
    output ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2,
    output ckInd, stbInd, ck1, stb1, ck2, stb2, ck3, stb3,
    output instDone, halted
  );
endinterface

// File: rtl/run_control.sv
// -----------------------------------------------------------------------------
// run_control
// Run/step qualification at instruction boundaries.
//   idle        in   sequencer is in IDLE
//   run         in   free-run level
//   step        in   single-step pulse
//   startInst   out  leave IDLE and fetch this clk
//   continueRun out  at end of instruction, fetch the next one directly
// step only matters in IDLE with run low; it is never remembered.
// -----------------------------------------------------------------------------
module run_control (
  input  logic idle,
  input  logic run,
  input  logic step,
  output logic startInst,
  output logic continueRun
);

  // Start decision from IDLE; run dominates, step only counts while halted.
  always_comb begin
    startInst = 1'b0;
    if (idle) begin
      if (run) begin
        startInst = 1'b1;
      end else begin
        startInst = step;
      end
    end else begin
      startInst = 1'b0;
    end
  end

  // Sampled by the sequencer only on the final exec strobe, so a mid-instruction
  // drop of run lets the instruction finish before halting.
  assign continueRun = run;

endmodule

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
// Major-cycle timing generator for the PDP-8 core: FETCH, optional AUTO1/AUTO2
// (autoincrement pointer), optional IND, then 1..3 execute ck/stb pairs.
//   clk    in  system clock
//   reset  in  synchronous, active-low
//   bus    slave side of cycle_sequencer_if (control in, phase outputs out)
// All outputs come from flops loaded with the decode of the next state.
// -----------------------------------------------------------------------------
module cycle_sequencer
  import pdp8_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cycle_sequencer_if.slave  bus
);

  seq_state_t            state;
  seq_state_t            next_state;
  logic [1:0]            exec_cnt;
  logic [NUM_PHASES-1:0] phase;
  logic                  inst_done;
  logic                  halted_q;
  logic                  done_next;
  logic                  idle;
  logic                  start_inst;
  logic                  continue_run;

  assign idle = (state == IDLE);

  run_control u_run_control (
    .idle        (idle),
    .run         (bus.run),
    .step        (bus.step),
    .startInst   (start_inst),
    .continueRun (continue_run)
  );

  // Next-state selection; exec_cnt is already latched by the time any EXn_STB runs.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_inst) next_state = FETCH_CK; else next_state = IDLE;
      FETCH_CK:  next_state = FETCH_STB;
      FETCH_STB: next_state = DISPATCH;
      DISPATCH: begin
        if (bus.instIsPPIND) begin
          next_state = AUTO1_CK;
        end else if (bus.instIsIND) begin
          next_state = IND_CK;
        end else begin
          next_state = EX1_CK;
        end
      end
      AUTO1_CK:  next_state = AUTO1_STB;
      AUTO1_STB: next_state = AUTO2_CK;
      AUTO2_CK:  next_state = AUTO2_STB;
      AUTO2_STB: next_state = IND_CK;
      IND_CK:    next_state = IND_STB;
      IND_STB:   next_state = EX1_CK;
      EX1_CK:    next_state = EX1_STB;
      EX1_STB: begin
        if (exec_cnt > 2'd1) begin
          next_state = EX2_CK;
        end else if (continue_run) begin
          next_state = FETCH_CK;
        end else begin
          next_state = IDLE;
        end
      end
      EX2_CK:    next_state = EX2_STB;
      EX2_STB: begin
        if (exec_cnt > 2'd2) begin
          next_state = EX3_CK;
        end else if (continue_run) begin
          next_state = FETCH_CK;
        end else begin
          next_state = IDLE;
        end
      end
      EX3_CK:    next_state = EX3_STB;
      EX3_STB: begin
        if (continue_run) begin
          next_state = FETCH_CK;
        end else begin
          next_state = IDLE;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // instDone is registered, so it is predicted from the strobe state being entered.
  always_comb begin
    done_next = 1'b0;
    case (next_state)
      EX1_STB: done_next = (exec_cnt == 2'd1);
      EX2_STB: done_next = (exec_cnt == 2'd2);
      EX3_STB: done_next = 1'b1;
      default: done_next = 1'b0;
    endcase
  end

  // State, step-count latch and registered output decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      exec_cnt  <= 2'd1;
      phase     <= {NUM_PHASES{1'b0}};
      inst_done <= 1'b0;
      halted_q  <= 1'b1;
    end else begin
      state     <= next_state;
      phase     <= phase_decode(next_state);
      inst_done <= done_next;
      halted_q  <= (next_state == IDLE);
      if (state == DISPATCH) begin
        exec_cnt <= norm_steps(bus.execSteps);
      end else begin
        exec_cnt <= exec_cnt;
      end
    end
  end

  assign bus.ckFetch  = phase[PH_CK_FETCH];
  assign bus.stbFetch = phase[PH_STB_FETCH];
  assign bus.ckAuto1  = phase[PH_CK_AUTO1];
  assign bus.stbAuto1 = phase[PH_STB_AUTO1];
  assign bus.ckAuto2  = phase[PH_CK_AUTO2];
  assign bus.stbAuto2 = phase[PH_STB_AUTO2];
  assign bus.ckInd    = phase[PH_CK_IND];
  assign bus.stbInd   = phase[PH_STB_IND];
  assign bus.ck1      = phase[PH_CK1];
  assign bus.stb1     = phase[PH_STB1];
  assign bus.ck2      = phase[PH_CK2];
  assign bus.stb2     = phase[PH_STB2];
  assign bus.ck3      = phase[PH_CK3];
  assign bus.stb3     = phase[PH_STB3];
  assign bus.instDone = inst_done;
  assign bus.halted   = halted_q;

endmodule
